lc3_mem_initiator: RTL and testbench

// Core-side initiator for the LC3 instruction/data memory handshake. Takes single-word

---
 rtl/lc3_mem_initiator.sv | 155 +++++++++++++++
 tb/tb_lc3_mem_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_initiator.sv
// lc3_mem_initiator: core-side initiator for the LC3 instruction/data memory handshake.
// Build macro LC3_MEMIF_TIMEOUT_EN adds a per-channel BUSY timeout with *_err reporting.
module lc3_mem_initiator #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_err,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic [ADDR_W-1:0] pc,
  output logic              instrmem_rd,
  input  logic [DATA_W-1:0] Instr_dout,
  input  logic              complete_instr,
  output logic [ADDR_W-1:0] Data_addr,
  output logic [DATA_W-1:0] Data_din,
  output logic              Data_rd,
  input  logic [DATA_W-1:0] Data_dout,
  input  logic              complete_data,
  output logic              fetch_busy_dbg,
  output logic              mem_busy_dbg
);

  // Handshake: a *_req is taken only while its channel is IDLE (IDLE acts as ready);
  // the access is then owned by the initiator until complete_* or a timeout, and the
  // result is reported by a one-cycle *_done pulse. Requests seen while BUSY are dropped.
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t f_state, m_state;
  logic   m_we_q;

`ifdef LC3_MEMIF_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] f_cnt, m_cnt;
`endif

  assign fetch_busy_dbg = (f_state == S_BUSY);
  assign mem_busy_dbg   = (m_state == S_BUSY);

  // Instruction channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_state     <= S_IDLE;
      pc          <= '0;
      instrmem_rd <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_instr <= '0;
`ifdef LC3_MEMIF_TIMEOUT_EN
      f_cnt       <= '0;
`endif
    end else begin
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      case (f_state)
        S_IDLE: begin
          if (fetch_req) begin
            pc          <= fetch_addr;
            instrmem_rd <= 1'b1;
            f_state     <= S_BUSY;
`ifdef LC3_MEMIF_TIMEOUT_EN
            f_cnt       <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (complete_instr) begin
            fetch_instr <= Instr_dout;
            instrmem_rd <= 1'b0;
            fetch_done  <= 1'b1;
            f_state     <= S_IDLE;
          end
`ifdef LC3_MEMIF_TIMEOUT_EN
          else if (f_cnt == TO_LAST) begin
            fetch_instr <= '0;
            instrmem_rd <= 1'b0;
            fetch_done  <= 1'b1;
            fetch_err   <= 1'b1;
            f_state     <= S_IDLE;
          end else begin
            f_cnt <= f_cnt + 8'd1;
          end
`endif
        end
        default: f_state <= S_IDLE;
      endcase
    end
  end

  // Data channel; Data_rd=0 means write, so it only drops while a store is outstanding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state   <= S_IDLE;
      m_we_q    <= 1'b0;
      Data_addr <= '0;
      Data_din  <= '0;
      Data_rd   <= 1'b1;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
`ifdef LC3_MEMIF_TIMEOUT_EN
      m_cnt     <= '0;
`endif
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      case (m_state)
        S_IDLE: begin
          if (mem_req) begin
            m_we_q    <= mem_we;
            Data_addr <= mem_addr;
            Data_din  <= mem_wdata;
            Data_rd   <= ~mem_we;
            m_state   <= S_BUSY;
`ifdef LC3_MEMIF_TIMEOUT_EN
            m_cnt     <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (complete_data) begin
            if (!m_we_q) mem_rdata <= Data_dout;
            Data_rd  <= 1'b1;
            mem_done <= 1'b1;
            m_state  <= S_IDLE;
          end
`ifdef LC3_MEMIF_TIMEOUT_EN
          else if (m_cnt == TO_LAST) begin
            if (!m_we_q) mem_rdata <= '0;
            Data_rd  <= 1'b1;
            mem_done <= 1'b1;
            mem_err  <= 1'b1;
            m_state  <= S_IDLE;
          end else begin
            m_cnt <= m_cnt + 8'd1;
          end
`endif
        end
        default: m_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_initiator.sv
// tb_lc3_mem_initiator: randomized bench for lc3_mem_initiator with a memory responder
// and a reference memory model; define LC3_MEMIF_TIMEOUT_EN to also exercise timeouts.
module tb_lc3_mem_initiator;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef LC3_MEMIF_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk, reset_n;
  logic          fetch_req, fetch_done, fetch_err;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_instr;
  logic          mem_req, mem_we, mem_done, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW-1:0] pc, Data_addr;
  logic          instrmem_rd, complete_instr, Data_rd, complete_data;
  logic [DW-1:0] Instr_dout, Data_din, Data_dout;
  logic          fetch_busy_dbg, mem_busy_dbg;

  lc3_mem_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(Instr_dout),
    .complete_instr(complete_instr),
    .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .fetch_busy_dbg(fetch_busy_dbg), .mem_busy_dbg(mem_busy_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard expectations, memory device contents and reference memory
  logic [DW-1:0] f_exp_q[$];
  logic [DW-1:0] m_exp_q[$];
  logic [DW-1:0] imem_dev [logic [AW-1:0]];
  logic [DW-1:0] dmem_dev [logic [AW-1:0]];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];
  logic [DW-1:0] last_instr, last_rdata;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
    return dmem_dev.exists(a) ? dmem_dev[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // lat = edge index (after acceptance) at which the memory reports completion, >= 1
  task automatic fetch_txn(input logic [AW-1:0] addr, input logic [DW-1:0] word,
                           input int lat, input bit chained, input bit hold_next,
                           input logic [AW-1:0] next_addr);
    logic [DW-1:0] exp;
    imem_dev[addr] = word;
    f_exp_q.push_back(word);
    if (!chained) begin
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      @(negedge clk);
    end
    fetch_req = 1'b0;
    check("fetch_strobe", instrmem_rd, 1);
    check("fetch_pc", pc, addr);
    check("fetch_busy_dbg", fetch_busy_dbg, 1);
    for (int i = 1; i < lat; i++) begin
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = 16'($urandom);
      @(negedge clk);
      check("fetch_hold_strobe", instrmem_rd, 1);
      check("fetch_hold_pc", pc, addr);
      check("fetch_early_done", fetch_done, 0);
    end
    fetch_req      = 1'b0;
    complete_instr = 1'b1;
    Instr_dout     = imem_dev.exists(pc) ? imem_dev[pc] : 16'hDEAD;
    @(negedge clk);
    complete_instr = 1'b0;
    Instr_dout     = 16'($urandom);
    exp = f_exp_q.pop_front();
    check("fetch_done", fetch_done, 1);
    check("fetch_instr", fetch_instr, exp);
    check("fetch_err", fetch_err, 0);
    check("fetch_strobe_drop", instrmem_rd, 0);
    last_instr = exp;
    if (hold_next) begin
      fetch_req  = 1'b1;
      fetch_addr = next_addr;
    end
    @(negedge clk);
    check("fetch_done_pulse", fetch_done, 0);
    check("fetch_instr_held", fetch_instr, exp);
  endtask

  task automatic mem_txn(input logic [AW-1:0] addr, input bit we,
                         input logic [DW-1:0] wdata, input int lat);
    logic [DW-1:0] exp;
    if (we) begin
      ref_mem[addr] = wdata;
      exp = last_rdata;
    end else begin
      exp = ref_read(addr);
    end
    m_exp_q.push_back(exp);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    @(negedge clk);
    mem_req = 1'b0;
    check("mem_strobe", Data_rd, {31'd0, !we});
    check("mem_addr", Data_addr, addr);
    if (we) check("mem_din", Data_din, wdata);
    for (int i = 1; i < lat; i++) begin
      mem_req   = 1'($urandom_range(0, 1));
      mem_we    = 1'($urandom_range(0, 1));
      mem_addr  = 16'($urandom);
      mem_wdata = 16'($urandom);
      @(negedge clk);
      check("mem_hold_strobe", Data_rd, {31'd0, !we});
      check("mem_hold_addr", Data_addr, addr);
      check("mem_early_done", mem_done, 0);
    end
    mem_req       = 1'b0;
    complete_data = 1'b1;
    if (!Data_rd) begin
      dmem_dev[Data_addr] = Data_din;
      Data_dout = 16'($urandom);
    end else begin
      Data_dout = dev_read(Data_addr);
    end
    @(negedge clk);
    complete_data = 1'b0;
    Data_dout     = 16'($urandom);
    exp = m_exp_q.pop_front();
    check("mem_done", mem_done, 1);
    check("mem_rdata", mem_rdata, exp);
    check("mem_err", mem_err, 0);
    check("mem_rd_idle", Data_rd, 1);
    last_rdata = exp;
    @(negedge clk);
    check("mem_done_pulse", mem_done, 0);
    check("mem_rd_after", Data_rd, 1);
    check("mem_rdata_held", mem_rdata, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_instrmem_rd"}, instrmem_rd, 0);
    check({tag, "_data_addr"}, Data_addr, 0);
    check({tag, "_data_din"}, Data_din, 0);
    check({tag, "_data_rd"}, Data_rd, 1);
    check({tag, "_dones"}, {fetch_done, mem_done}, 0);
    check({tag, "_errs"}, {fetch_err, mem_err}, 0);
    check({tag, "_fetch_instr"}, fetch_instr, 0);
    check({tag, "_mem_rdata"}, mem_rdata, 0);
    check({tag, "_busy_dbg"}, {fetch_busy_dbg, mem_busy_dbg}, 0);
  endtask

  initial begin : main
    int kind;
    int k;
    logic [AW-1:0] a;
    reset_n = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    Instr_dout = '0; complete_instr = 1'b0;
    Data_dout = '0; complete_data = 1'b0;
    last_instr = '0; last_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // directed cases
    fetch_txn(16'h3000, 16'h1261, 1, 1'b0, 1'b0, '0);
    mem_txn(16'h4000, 1'b1, 16'hBEEF, 4);
    mem_txn(16'h4000, 1'b0, 16'h0000, 2);
    fork
      fetch_txn(16'h3010, 16'h5A5A, 3, 1'b0, 1'b0, '0);
      mem_txn(16'h4000, 1'b0, 16'h0000, 3);
    join
    fetch_txn(16'h3001, 16'h2222, 2, 1'b0, 1'b1, 16'h3002);
    fetch_txn(16'h3002, 16'h3333, 1, 1'b1, 1'b0, '0);

    // completes while idle must be ignored
    @(negedge clk);
    complete_instr = 1'b1; complete_data = 1'b1;
    Instr_dout = 16'hFFFF; Data_dout = 16'hFFFF;
    @(negedge clk);
    complete_instr = 1'b0; complete_data = 1'b0;
    check("idle_complete_done", {fetch_done, mem_done}, 0);
    check("idle_complete_instr", fetch_instr, last_instr);
    check("idle_complete_rdata", mem_rdata, last_rdata);

    // asynchronous reset two cycles into a store
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h4100; mem_wdata = 16'h1234;
    @(negedge clk);
    mem_req = 1'b0;
    check("rst_store_busy", Data_rd, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", mem_done, 0);
    end
    reset_n = 1'b1;
    last_instr = '0; last_rdata = '0;
    mem_txn(16'h4100, 1'b0, 16'h0000, 2);

    // randomized mix
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      a = 16'h4000 + 16'($urandom_range(0, 7));
      case (kind)
        0: fetch_txn(16'($urandom), 16'($urandom), $urandom_range(1, 5), 1'b0, 1'b0, '0);
        1: mem_txn(a, 1'b1, 16'($urandom), $urandom_range(1, 5));
        2: mem_txn(a, 1'b0, 16'h0000, $urandom_range(1, 5));
        default: fork
          fetch_txn(16'($urandom), 16'($urandom), $urandom_range(1, 5), 1'b0, 1'b0, '0);
          mem_txn(a, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 5));
        join
      endcase
    end

`ifdef LC3_MEMIF_TIMEOUT_EN
    // load with no completion must time out after TO busy cycles
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h4000;
    @(negedge clk);
    mem_req = 1'b0;
    k = 1;
    while (k <= 40 && !mem_done) begin
      @(negedge clk);
      k++;
    end
    check("mem_to_latency", k, TO + 1);
    check("mem_to_err", mem_err, 1);
    check("mem_to_rdata", mem_rdata, 0);
    check("mem_to_rd", Data_rd, 1);
    last_rdata = '0;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 16'h3abc;
    @(negedge clk);
    fetch_req = 1'b0;
    k = 1;
    while (k <= 40 && !fetch_done) begin
      @(negedge clk);
      k++;
    end
    check("fetch_to_latency", k, TO + 1);
    check("fetch_to_err", fetch_err, 1);
    check("fetch_to_instr", fetch_instr, 0);
    check("fetch_to_strobe", instrmem_rd, 0);
    last_instr = '0;
    // completion on the timeout edge wins
    mem_txn(16'h4001, 1'b0, 16'h0000, TO);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
